// File: rtl/trinity_pkg.sv
// Shared definitions for the hashrate monitors: FSM encoding, default
// parameter values and a 64-to-32 bit saturation helper.
package trinity_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2
    } meter_state_e;

    localparam logic [31:0] DEF_WINDOW_CYCLES   = 32'd100_000_000;
    localparam logic [31:0] DEF_HASHES_PER_DONE = 32'd1;
    localparam logic [31:0] DEF_STALL_WINDOWS   = 32'd3;

    function automatic logic [31:0] sat32(input logic [63:0] value);
        return (|value[63:32]) ? 32'hFFFF_FFFF : value[31:0];
    endfunction

endpackage

// File: rtl/window_timer.sv
// Free-running window counter: counts 0..WINDOW_CYCLES-1 while enabled and
// strobes tick on the last cycle of each window.
module window_timer
    import trinity_pkg::*;
#(
    parameter logic [31:0] WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    logic [31:0] count;

    assign tick = enable && (count == WINDOW_CYCLES - 32'd1);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? 32'd0 : count + 32'd1;
        end
    end

endmodule

// File: rtl/hashrate_meter.sv
// Measures done-pulse rate per window, reports raw and smoothed hashrate,
// and flags a stall after consecutive windows below threshold.
module hashrate_meter
    import trinity_pkg::*;
#(
    parameter logic [31:0] WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter logic [31:0] HASHES_PER_DONE = DEF_HASHES_PER_DONE,
    parameter logic [31:0] STALL_WINDOWS   = DEF_STALL_WINDOWS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        done_pulse,
    input  logic [31:0] threshold,
    output logic [31:0] current_hashrate,
    output logic [31:0] smoothed_hashrate,
    output logic        rate_valid,
    output logic        stall,
    output logic        warm
);

    logic         tick;
    logic [31:0]  pulse_count;
    logic [31:0]  window_pulses;
    logic [31:0]  raw;
    logic [31:0]  low_count;
    logic [31:0]  low_next;
    logic [33:0]  smooth_sum;
    meter_state_e state;
    meter_state_e state_next;

    window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_window_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    // Includes this cycle's pulse so a pulse on the window-end cycle lands
    // in the ending window.
    assign window_pulses = (done_pulse && (pulse_count != 32'hFFFF_FFFF))
                         ? pulse_count + 32'd1 : pulse_count;
    assign raw        = sat32(64'(window_pulses) * 64'(HASHES_PER_DONE));
    assign smooth_sum = 34'({smoothed_hashrate, 1'b0}) + 34'(smoothed_hashrate) + 34'(raw);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        low_next = 32'd0;
        if (raw < threshold) begin
            low_next = (low_count < STALL_WINDOWS) ? low_count + 32'd1 : low_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_WARMUP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                ST_WARMUP, ST_RUN: begin
                    // A zero threshold can never make a window count as low.
                    state_next = ((threshold != 32'd0) && (low_next >= STALL_WINDOWS))
                               ? ST_STALL : ST_RUN;
                end
                ST_STALL: begin
                    if (raw >= threshold) state_next = ST_RUN;
                end
                default: state_next = ST_WARMUP;
            endcase
        end
    end

    always_comb begin
        stall = (state == ST_STALL);
        warm  = (state != ST_WARMUP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_count       <= '0;
            low_count         <= '0;
            current_hashrate  <= '0;
            smoothed_hashrate <= '0;
            rate_valid        <= 1'b0;
        end else begin
            rate_valid <= tick;
            if (enable) begin
                pulse_count <= tick ? 32'd0 : window_pulses;
            end
            if (tick) begin
                low_count         <= low_next;
                current_hashrate  <= raw;
                smoothed_hashrate <= warm ? smooth_sum[33:2] : raw;
            end
        end
    end

endmodule

// File: tb/tb_hashrate_meter.sv
// Directed bench for hashrate_meter with WINDOW_CYCLES=10, HASHES_PER_DONE=4,
// STALL_WINDOWS=2; expected values are hand-computed per scenario.
module tb_hashrate_meter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        done_pulse;
    logic [31:0] threshold;
    logic [31:0] current_hashrate;
    logic [31:0] smoothed_hashrate;
    logic        rate_valid;
    logic        stall;
    logic        warm;

    int total = 0;
    int bad   = 0;

    hashrate_meter #(
        .WINDOW_CYCLES   (32'd10),
        .HASHES_PER_DONE (32'd4),
        .STALL_WINDOWS   (32'd2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .done_pulse        (done_pulse),
        .threshold         (threshold),
        .current_hashrate  (current_hashrate),
        .smoothed_hashrate (smoothed_hashrate),
        .rate_valid        (rate_valid),
        .stall             (stall),
        .warm              (warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives done_pulse for n cycles; returns 1 time unit after the last edge.
    task automatic run(input int n, input logic dp);
        for (int i = 0; i < n; i++) begin
            done_pulse = dp;
            @(posedge clk);
            #1;
        end
        done_pulse = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; done_pulse = 1'b0; threshold = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (current_hashrate !== 32'd0) begin bad++; $display("FAIL reset_current got=%0d exp=0", current_hashrate); end
        total++; if (smoothed_hashrate !== 32'd0) begin bad++; $display("FAIL reset_smoothed got=%0d exp=0", smoothed_hashrate); end
        total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rate_valid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (warm !== 1'b0) begin bad++; $display("FAIL reset_warm got=%b exp=0", warm); end
        rst = 1'b0;
    endtask

    task automatic test_first_window;
        enable = 1'b1;
        run(5, 1'b1);
        run(4, 1'b0);
        total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL w1_early_valid got=%b exp=0", rate_valid); end
        run(1, 1'b0);
        total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL w1_valid got=%b exp=1", rate_valid); end
        total++; if (current_hashrate !== 32'd20) begin bad++; $display("FAIL w1_current got=%0d exp=20", current_hashrate); end
        total++; if (smoothed_hashrate !== 32'd20) begin bad++; $display("FAIL w1_smoothed got=%0d exp=20", smoothed_hashrate); end
        total++; if (warm !== 1'b1) begin bad++; $display("FAIL w1_warm got=%b exp=1", warm); end
    endtask

    task automatic test_second_window;
        run(1, 1'b1);
        total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL w2_valid_drop got=%b exp=0", rate_valid); end
        total++; if (current_hashrate !== 32'd20) begin bad++; $display("FAIL w2_hold_current got=%0d exp=20", current_hashrate); end
        run(9, 1'b0);
        total++; if (current_hashrate !== 32'd4) begin bad++; $display("FAIL w2_current got=%0d exp=4", current_hashrate); end
        total++; if (smoothed_hashrate !== 32'd16) begin bad++; $display("FAIL w2_smoothed got=%0d exp=16", smoothed_hashrate); end
    endtask

    task automatic test_stall;
        threshold = 32'd10;
        run(1, 1'b1); run(9, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL w3_stall got=%b exp=0", stall); end
        total++; if (smoothed_hashrate !== 32'd13) begin bad++; $display("FAIL w3_smoothed got=%0d exp=13", smoothed_hashrate); end
        run(1, 1'b1); run(9, 1'b0);
        total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL w4_valid got=%b exp=1", rate_valid); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL w4_stall got=%b exp=1", stall); end
        total++; if (smoothed_hashrate !== 32'd10) begin bad++; $display("FAIL w4_smoothed got=%0d exp=10", smoothed_hashrate); end
        run(3, 1'b1); run(7, 1'b0);
        total++; if (current_hashrate !== 32'd12) begin bad++; $display("FAIL w5_current got=%0d exp=12", current_hashrate); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL w5_stall got=%b exp=0", stall); end
        total++; if (smoothed_hashrate !== 32'd10) begin bad++; $display("FAIL w5_smoothed got=%0d exp=10", smoothed_hashrate); end
        threshold = 32'd0;
    endtask

    task automatic test_window_end_pulse;
        run(9, 1'b0); run(1, 1'b1);
        total++; if (current_hashrate !== 32'd4) begin bad++; $display("FAIL w6_end_pulse got=%0d exp=4", current_hashrate); end
        total++; if (smoothed_hashrate !== 32'd8) begin bad++; $display("FAIL w6_smoothed got=%0d exp=8", smoothed_hashrate); end
        run(1, 1'b1); run(9, 1'b0);
        total++; if (current_hashrate !== 32'd4) begin bad++; $display("FAIL w7_next_pulse got=%0d exp=4", current_hashrate); end
        total++; if (smoothed_hashrate !== 32'd7) begin bad++; $display("FAIL w7_smoothed got=%0d exp=7", smoothed_hashrate); end
    endtask

    task automatic test_enable_hold;
        run(3, 1'b1);
        enable = 1'b0;
        run(7, 1'b1);
        total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b exp=0", rate_valid); end
        total++; if (current_hashrate !== 32'd4) begin bad++; $display("FAIL hold_current got=%0d exp=4", current_hashrate); end
        enable = 1'b1;
        run(6, 1'b0);
        total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL hold_early_valid got=%b exp=0", rate_valid); end
        run(1, 1'b0);
        total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL hold_delayed_valid got=%b exp=1", rate_valid); end
        total++; if (current_hashrate !== 32'd12) begin bad++; $display("FAIL hold_count got=%0d exp=12", current_hashrate); end
        total++; if (smoothed_hashrate !== 32'd8) begin bad++; $display("FAIL hold_smoothed got=%0d exp=8", smoothed_hashrate); end
    endtask

    task automatic test_reset_mid_window;
        run(4, 1'b1);
        rst = 1'b1;
        #1;
        total++; if (current_hashrate !== 32'd0) begin bad++; $display("FAIL mid_rst_current got=%0d exp=0", current_hashrate); end
        total++; if (smoothed_hashrate !== 32'd0) begin bad++; $display("FAIL mid_rst_smoothed got=%0d exp=0", smoothed_hashrate); end
        total++; if (warm !== 1'b0) begin bad++; $display("FAIL mid_rst_warm got=%b exp=0", warm); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(9, 1'b1);
        total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL post_rst_early_valid got=%b exp=0", rate_valid); end
        run(1, 1'b0);
        total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL post_rst_valid got=%b exp=1", rate_valid); end
        total++; if (current_hashrate !== 32'd36) begin bad++; $display("FAIL post_rst_current got=%0d exp=36", current_hashrate); end
        total++; if (smoothed_hashrate !== 32'd36) begin bad++; $display("FAIL post_rst_smoothed got=%0d exp=36", smoothed_hashrate); end
        total++; if (warm !== 1'b1) begin bad++; $display("FAIL post_rst_warm got=%b exp=1", warm); end
    endtask

    initial begin
        test_reset;
        test_first_window;
        test_second_window;
        test_stall;
        test_window_end_pulse;
        test_enable_hold;
        test_reset_mid_window;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
